// File: rtl/vend_dispenser_pkg.sv
// vend_pkg: state encoding, default timing/stock constants and timer width helper for the dispenser
package vend_pkg;
  typedef enum logic [2:0] {IDLE, DROP_PULSE, DROP_WAIT, CHG_PULSE, CHG_WAIT, DONE, FAULT} state_t;
  localparam int PULSE_CYC_DEF = 8;
  localparam int TIMEOUT_CYC_DEF = 64;
  localparam int STOCK_W_DEF = 4;
  function automatic int tmr_w(input int p, input int t);
    int m;
    m = p > t ? p : t;
    return m < 2 ? 1 : $clog2(m);
  endfunction
endpackage

// File: rtl/vend_dispenser_if.sv
// vend_dispenser_if: controller/sensor side of the dispenser; no_change exists only with COIN_STOCK_EN
interface vend_dispenser_if;
  logic drop_req, change_req, item_sensed, coin_sensed, refill;
  logic solenoid_on, hopper_on, busy, dispense_done, reject, sold_out, fault;
`ifdef COIN_STOCK_EN
  logic no_change;
`endif
  modport master(
`ifdef COIN_STOCK_EN
    input no_change,
`endif
    output drop_req, change_req, item_sensed, coin_sensed, refill,
    input solenoid_on, hopper_on, busy, dispense_done, reject, sold_out, fault
  );
  modport slave(
`ifdef COIN_STOCK_EN
    output no_change,
`endif
    input drop_req, change_req, item_sensed, coin_sensed, refill,
    output solenoid_on, hopper_on, busy, dispense_done, reject, sold_out, fault
  );
endinterface

// File: rtl/vend_dispenser_timer.sv
// vend_actuator_timer: shared up-counter restarted on every state change; flags pulse end and wait timeout
module vend_actuator_timer import vend_pkg::*; #(
  parameter int PULSE_CYC = PULSE_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic pulse_done,
  output logic timeout
);
  localparam int W = tmr_w(PULSE_CYC, TIMEOUT_CYC);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= start ? '0 : cnt + W'(1);
  assign pulse_done = cnt == W'(PULSE_CYC - 1);
  assign timeout = cnt == W'(TIMEOUT_CYC - 1);
endmodule

// File: rtl/vend_dispenser.sv
// vend_dispenser: sequences solenoid then optional hopper with sensor confirmation, stock and sticky fault
// COIN_STOCK_EN adds a change-coin counter, the no_change status and refusal of change when empty
module vend_dispenser import vend_pkg::*; #(
  parameter int PULSE_CYC = PULSE_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int STOCK_W = STOCK_W_DEF,
  parameter int STOCK_INIT = 15
`ifdef COIN_STOCK_EN
  , parameter int COIN_INIT = 15
`endif
) (
  input logic clk,
  input logic reset,
  vend_dispenser_if.slave bus
);
  state_t st, nxt;
  logic [STOCK_W-1:0] stock;
  logic chg_pend, seen, sens, hit, start, pulse_done, timeout, refuse, take, reload, drop_cfm;
  // a sensor edge during the pulse is remembered so it can confirm at pulse end
  assign sens = (st == DROP_PULSE || st == DROP_WAIT) ? bus.item_sensed : bus.coin_sensed;
  assign hit = seen | sens;
  assign drop_cfm = hit && (st == DROP_WAIT || (st == DROP_PULSE && pulse_done));
  assign take = st == IDLE && bus.drop_req && !refuse;
  assign reload = st == IDLE && bus.refill && !bus.drop_req;
  assign start = nxt != st;
`ifdef COIN_STOCK_EN
  logic [STOCK_W-1:0] coins;
  logic chg_cfm;
  assign chg_cfm = hit && (st == CHG_WAIT || (st == CHG_PULSE && pulse_done));
  assign refuse = stock == '0 || (bus.change_req && coins == '0);
  always_ff @(posedge clk or posedge reset)
    if (reset) coins <= STOCK_W'(COIN_INIT);
    else if (chg_cfm) coins <= coins - STOCK_W'(coins != '0);
    else if (reload) coins <= STOCK_W'(COIN_INIT);
  assign bus.no_change = coins == '0;
`else
  assign refuse = stock == '0;
`endif
  vend_actuator_timer #(.PULSE_CYC(PULSE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) u_tmr (
    .clk(clk), .reset(reset), .start(start), .pulse_done(pulse_done), .timeout(timeout)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) st <= IDLE;
    else st <= nxt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      stock <= STOCK_W'(STOCK_INIT);
      chg_pend <= 1'b0;
      seen <= 1'b0;
    end else begin
      seen <= start ? 1'b0 : hit;
      chg_pend <= take ? bus.change_req : (st == DONE ? 1'b0 : chg_pend);
      if (drop_cfm) stock <= stock - STOCK_W'(stock != '0);
      else if (reload) stock <= STOCK_W'(STOCK_INIT);
    end
  always_comb begin
    nxt = st;
    case (st)
      IDLE:       nxt = take ? DROP_PULSE : IDLE;
      DROP_PULSE: nxt = pulse_done ? (hit ? (chg_pend ? CHG_PULSE : DONE) : DROP_WAIT) : DROP_PULSE;
      DROP_WAIT:  nxt = hit ? (chg_pend ? CHG_PULSE : DONE) : (timeout ? FAULT : DROP_WAIT);
      CHG_PULSE:  nxt = pulse_done ? (hit ? DONE : CHG_WAIT) : CHG_PULSE;
      CHG_WAIT:   nxt = hit ? DONE : (timeout ? FAULT : CHG_WAIT);
      DONE:       nxt = IDLE;
      FAULT:      nxt = FAULT;
      default:    nxt = IDLE;
    endcase
  end
  always_comb begin
    bus.solenoid_on = st == DROP_PULSE;
    bus.hopper_on = st == CHG_PULSE;
    bus.busy = st != IDLE;
    bus.dispense_done = st == DONE;
    bus.reject = st == IDLE && bus.drop_req && refuse;
    bus.sold_out = stock == '0;
    bus.fault = st == FAULT;
  end
endmodule
